// File: rtl/cpu_bus_arbiter.sv
// Arbitrates CPU instruction-fetch and data accesses onto one shared memory bus.
// Data access goes first; the CPU is stalled until both are served, then released for one cycle.
module cpu_bus_arbiter #(
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 im_read_mem,
  input  logic [31:0]          im_addr,
  output logic [DATA_SIZE-1:0] im_dataout,
  input  logic                 dm_read_mem,
  input  logic                 dm_write_mem,
  input  logic [31:0]          dm_addr,
  input  logic [DATA_SIZE-1:0] dm_datain,
  input  logic [3:0]           dm_web,
  output logic [DATA_SIZE-1:0] dm_dataout,
  output logic                 bus_stall,
  output logic                 m_req,
  output logic                 m_write,
  output logic [31:0]          m_addr,
  output logic [DATA_SIZE-1:0] m_wdata,
  output logic [3:0]           m_wstrb,
  input  logic                 m_gnt,
  input  logic                 m_done,
  input  logic [DATA_SIZE-1:0] m_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StDmReq,
    StDmWait,
    StImReq,
    StImWait,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [31:0]          im_addr_q, dm_addr_q;
  logic [DATA_SIZE-1:0] dm_wdata_q;
  logic [3:0]           dm_wstrb_q;
  logic                 dm_write_q, im_pend_q;
  logic [DATA_SIZE-1:0] im_data_q, dm_data_q;

  logic dm_is_write, dm_pend, any_pend, latch_en;

  // A write with every byte disabled is no access at all.
  assign dm_is_write = dm_write_mem & (dm_web != 4'b1111);
  assign dm_pend     = dm_read_mem | dm_is_write;
  assign any_pend    = dm_pend | im_read_mem;

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_pend) begin
          latch_en = 1'b1;
          state_d  = dm_pend ? StDmReq : StImReq;
        end
      end
      StDmReq:  if (m_gnt) state_d = StDmWait;
      StDmWait: if (m_done) state_d = im_pend_q ? StImReq : StDone;
      StImReq:  if (m_gnt) state_d = StImWait;
      StImWait: if (m_done) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    m_req     = 1'b0;
    m_write   = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = 4'b0000;
    bus_stall = 1'b1;
    unique case (state_q)
      StIdle: bus_stall = any_pend;
      StDmReq: begin
        m_req   = 1'b1;
        m_write = dm_write_q;
        m_addr  = dm_addr_q;
        m_wdata = dm_wdata_q;
        m_wstrb = dm_wstrb_q;
      end
      StImReq: begin
        m_req  = 1'b1;
        m_addr = im_addr_q;
      end
      StDone:  bus_stall = 1'b0;
      default: bus_stall = 1'b1;
    endcase
    // Reset forces the state to idle, but pending request lines must not stall the CPU.
    if (rst) bus_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      im_addr_q  <= '0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_wstrb_q <= 4'b0000;
      dm_write_q <= 1'b0;
      im_pend_q  <= 1'b0;
      im_data_q  <= '0;
      dm_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        im_addr_q  <= im_addr;
        dm_addr_q  <= dm_addr;
        dm_wdata_q <= dm_datain;
        dm_wstrb_q <= ~dm_web;
        dm_write_q <= dm_is_write;
        im_pend_q  <= im_read_mem;
      end
      if ((state_q == StDmWait) && m_done && !dm_write_q) dm_data_q <= m_rdata;
      if ((state_q == StImWait) && m_done) im_data_q <= m_rdata;
    end
  end

  assign im_dataout = im_data_q;
  assign dm_dataout = dm_data_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: a bus responder with programmable grant/done delays,
// and a transaction-level model predicting bus order, stall counts and returned data.
module tb_cpu_bus_arbiter;

  localparam int unsigned DW = 32;

  logic          clk, rst;
  logic          im_read_mem;
  logic [31:0]   im_addr;
  logic [DW-1:0] im_dataout;
  logic          dm_read_mem, dm_write_mem;
  logic [31:0]   dm_addr;
  logic [DW-1:0] dm_datain;
  logic [3:0]    dm_web;
  logic [DW-1:0] dm_dataout;
  logic          bus_stall, m_req, m_write;
  logic [31:0]   m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_gnt, m_done;
  logic [DW-1:0] m_rdata;

  logic          r_gnt, r_done, t_done;
  logic [DW-1:0] r_rdata, t_rdata;

  assign m_gnt   = r_gnt;
  assign m_done  = r_done | t_done;
  assign m_rdata = t_done ? t_rdata : r_rdata;

  int checks, errors, proto_err, gnt_delay, done_delay;
  logic [DW-1:0] exp_im, exp_dm;
  logic [DW-1:0] mem [logic [31:0]];
  logic [31:0]   log_addr[$];
  logic          log_write[$];
  logic [DW-1:0] log_wdata[$];
  logic [3:0]    log_wstrb[$];

  cpu_bus_arbiter #(.DATA_SIZE(DW)) dut (
    .clk(clk), .rst(rst),
    .im_read_mem(im_read_mem), .im_addr(im_addr), .im_dataout(im_dataout),
    .dm_read_mem(dm_read_mem), .dm_write_mem(dm_write_mem), .dm_addr(dm_addr),
    .dm_datain(dm_datain), .dm_web(dm_web), .dm_dataout(dm_dataout),
    .bus_stall(bus_stall), .m_req(m_req), .m_write(m_write), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_gnt(m_gnt), .m_done(m_done), .m_rdata(m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rd_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
  endfunction

  // Bus slave: grants gnt_delay cycles after a request appears, completes done_delay cycles later.
  initial begin
    int rs;
    int rcnt;
    logic [31:0] cur;
    rs = 0; rcnt = 0; cur = '0;
    r_gnt = 1'b0; r_done = 1'b0; r_rdata = '0; proto_err = 0;
    forever begin
      @(negedge clk);
      r_gnt  = 1'b0;
      r_done = 1'b0;
      if (rst) begin
        rs = 0;
      end else if (rs == 2) begin
        if (m_req) proto_err++;
        if (rcnt >= done_delay) begin
          r_done  = 1'b1;
          r_rdata = rd_val(cur);
          rs      = 0;
        end else rcnt++;
      end else begin
        if (rs == 0 && m_req) begin rs = 1; rcnt = 0; end
        if (rs == 1) begin
          if (rcnt >= gnt_delay) begin
            r_gnt = 1'b1;
            cur   = m_addr;
            log_addr.push_back(m_addr);
            log_write.push_back(m_write);
            log_wdata.push_back(m_wdata);
            log_wstrb.push_back(m_wstrb);
            rs = 2; rcnt = 0;
          end else rcnt++;
        end
      end
    end
  end

  task automatic set_idle();
    im_read_mem = 1'b0; im_addr = '0; dm_read_mem = 1'b0; dm_write_mem = 1'b0;
    dm_addr = '0; dm_datain = '0; dm_web = 4'hF;
  endtask

  // Presents one CPU request set, runs it to release, and checks everything the model predicts.
  task automatic drive_access(input string tag, input logic rd, input logic wr,
                              input logic [3:0] web, input logic [31:0] daddr,
                              input logic [DW-1:0] wdata, input logic fetch,
                              input logic [31:0] iaddr, input int gd, input int dd);
    logic dm_acc;
    int n_exp, exp_stall, exp_reqc, base, stalls, reqc, unstable;
    bit done_seen, prev_req;
    logic [31:0] ea[2];
    logic ew[2];
    logic [3:0] es[2];
    logic [DW-1:0] ed[2];
    logic [31:0] p_a;
    logic p_w;
    logic [3:0] p_s;
    logic [DW-1:0] p_d;
    dm_acc = rd | (wr & (web != 4'hF));
    n_exp = 0;
    if (dm_acc) begin
      ea[0] = daddr; ew[0] = ~rd; es[0] = ~web; ed[0] = wdata; n_exp = 1;
    end
    if (fetch) begin
      ea[n_exp] = iaddr; ew[n_exp] = 1'b0; es[n_exp] = 4'h0; ed[n_exp] = '0; n_exp++;
    end
    exp_stall = (n_exp == 0) ? 0 : 1 + n_exp * (gd + dd + 2);
    exp_reqc  = n_exp * (gd + 1);
    if (dm_acc && rd) exp_dm = rd_val(daddr);
    if (fetch) exp_im = rd_val(iaddr);
    gnt_delay = gd; done_delay = dd;
    base = log_addr.size();
    dm_read_mem = rd; dm_write_mem = wr; dm_web = web; dm_addr = daddr; dm_datain = wdata;
    im_read_mem = fetch; im_addr = iaddr;
    stalls = 0; reqc = 0; unstable = 0; done_seen = 0; prev_req = 0;
    p_a = '0; p_w = 1'b0; p_s = '0; p_d = '0;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      @(negedge clk);
      if (m_req) begin
        reqc++;
        if (prev_req && {p_a, p_w, p_s, p_d} !== {m_addr, m_write, m_wstrb, m_wdata}) unstable++;
        p_a = m_addr; p_w = m_write; p_s = m_wstrb; p_d = m_wdata;
      end
      prev_req = m_req;
      if (bus_stall) stalls++;
      else done_seen = 1;
    end
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL %s release: bus_stall never fell after %0d cycles", tag, stalls);
    end
    checks++;
    if (stalls != exp_stall) begin
      errors++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, exp_stall);
    end
    checks++;
    if (m_req !== 1'b0) begin
      errors++; $display("FAIL %s req_at_release: got %b want 0", tag, m_req);
    end
    checks++;
    if (im_dataout !== exp_im) begin
      errors++; $display("FAIL %s im_dataout: got %h want %h", tag, im_dataout, exp_im);
    end
    checks++;
    if (dm_dataout !== exp_dm) begin
      errors++; $display("FAIL %s dm_dataout: got %h want %h", tag, dm_dataout, exp_dm);
    end
    checks++;
    if (log_addr.size() - base != n_exp) begin
      errors++;
      $display("FAIL %s txn_count: got %0d want %0d", tag, log_addr.size() - base, n_exp);
    end
    checks++;
    if (reqc != exp_reqc || unstable != 0) begin
      errors++;
      $display("FAIL %s req_hold: got %0d cycles (%0d changes) want %0d cycles (0 changes)",
               tag, reqc, unstable, exp_reqc);
    end
    for (int i = 0; i < n_exp && base + i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[base+i] !== ea[i] || log_write[base+i] !== ew[i] ||
          log_wstrb[base+i] !== es[i] || (ew[i] && log_wdata[base+i] !== ed[i])) begin
        errors++;
        $display("FAIL %s txn%0d: got a=%h w=%b s=%b d=%h want a=%h w=%b s=%b d=%h", tag, i,
                 log_addr[base+i], log_write[base+i], log_wstrb[base+i], log_wdata[base+i],
                 ea[i], ew[i], es[i], ed[i]);
      end
    end
    if (n_exp == 0) begin
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (m_req !== 1'b0 || bus_stall !== 1'b0) begin
          errors++; $display("FAIL %s no_access: got req=%b stall=%b want 0 0", tag, m_req, bus_stall);
        end
      end
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    checks++;
    if (m_req !== 1'b0 || bus_stall !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: got req=%b stall=%b want 0 0", tag, m_req, bus_stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    im_read_mem = 1'b1; im_addr = 32'h44; dm_read_mem = 1'b1; dm_addr = 32'h88;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_stall !== 1'b0 || m_req !== 1'b0 || m_write !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got stall=%b req=%b wr=%b want 0 0 0",
                         bus_stall, m_req, m_write);
    end
    checks++;
    if (m_addr !== '0 || m_wdata !== '0 || m_wstrb !== '0) begin
      errors++; $display("FAIL reset_bus: got a=%h d=%h s=%b want 0", m_addr, m_wdata, m_wstrb);
    end
    checks++;
    if (im_dataout !== '0 || dm_dataout !== '0) begin
      errors++; $display("FAIL reset_data: got im=%h dm=%h want 0 0", im_dataout, dm_dataout);
    end
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_im = '0; exp_dm = '0;
    @(negedge clk);
    checks++;
    if (bus_stall !== 1'b0 || m_req !== 1'b0) begin
      errors++; $display("FAIL reset_release: got stall=%b req=%b want 0 0", bus_stall, m_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_only();
    drive_access("fetch_only", 1'b0, 1'b0, 4'hF, 32'h0, '0, 1'b1, 32'h10, 0, 0);
  endtask

  task automatic test_load_fetch();
    drive_access("load_fetch", 1'b1, 1'b0, 4'hF, 32'h0001_0004, '0, 1'b1, 32'h14, 0, 0);
  endtask

  task automatic test_store_delayed_gnt();
    drive_access("store_gnt4", 1'b0, 1'b1, 4'b1100, 32'h0000_0200, 32'h0000_ABCD, 1'b0, 32'h0,
                 4, 0);
  endtask

  task automatic test_masked_write();
    drive_access("masked_write", 1'b0, 1'b1, 4'hF, 32'h300, 32'h1234_5678, 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_reset_mid_txn();
    gnt_delay = 0; done_delay = 20;
    dm_read_mem = 1'b1; dm_addr = 32'h2000; dm_web = 4'hF; im_read_mem = 1'b1; im_addr = 32'h24;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (bus_stall !== 1'b1 || m_req !== 1'b0) begin
      errors++; $display("FAIL rst_mid_wait: got stall=%b req=%b want 1 0", bus_stall, m_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_req !== 1'b0 || bus_stall !== 1'b0 || m_addr !== '0 || m_wstrb !== '0) begin
      errors++; $display("FAIL rst_mid_abort: got req=%b stall=%b a=%h s=%b want all 0",
                         m_req, bus_stall, m_addr, m_wstrb);
    end
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_im = '0; exp_dm = '0;
    t_rdata = 32'hBAD0_BAD0; t_done = 1'b1;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b0 || bus_stall !== 1'b0) begin
      errors++; $display("FAIL rst_spurious_done: got req=%b stall=%b want 0 0", m_req, bus_stall);
    end
    @(posedge clk); #1;
    t_done = 1'b0;
    @(negedge clk);
    checks++;
    if (dm_dataout !== '0 || im_dataout !== '0 || bus_stall !== 1'b0) begin
      errors++; $display("FAIL rst_no_capture: got dm=%h im=%h stall=%b want 0 0 0",
                         dm_dataout, im_dataout, bus_stall);
    end
    @(posedge clk); #1;
    drive_access("after_reset", 1'b1, 1'b0, 4'hF, 32'h2000, '0, 1'b1, 32'h24, 1, 1);
  endtask

  task automatic test_back_to_back();
    int base, dones, consec;
    bit prev_ns;
    gnt_delay = 0; done_delay = 0;
    base = log_addr.size(); dones = 0; consec = 0; prev_ns = 0;
    dm_read_mem = 1'b1; dm_addr = 32'h3000; dm_web = 4'hF; im_read_mem = 1'b1; im_addr = 32'h40;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!bus_stall) begin
        dones++;
        if (prev_ns) consec++;
        prev_ns = 1;
      end else prev_ns = 0;
    end
    exp_dm = rd_val(32'h3000); exp_im = rd_val(32'h40);
    checks++;
    if (dones != 5 || consec != 0) begin
      errors++; $display("FAIL b2b_done: got %0d releases (%0d adjacent) want 5 (0)", dones, consec);
    end
    checks++;
    if (log_addr.size() - base != 10) begin
      errors++; $display("FAIL b2b_txns: got %0d want 10", log_addr.size() - base);
    end
    for (int i = 0; i < 10 && base + i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[base+i] !== ((i % 2 == 0) ? 32'h3000 : 32'h40)) begin
        errors++; $display("FAIL b2b_order%0d: got %h want %h", i, log_addr[base+i],
                           (i % 2 == 0) ? 32'h3000 : 32'h40);
      end
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    checks++;
    if (im_dataout !== exp_im || dm_dataout !== exp_dm) begin
      errors++; $display("FAIL b2b_data: got im=%h dm=%h want %h %h",
                         im_dataout, dm_dataout, exp_im, exp_dm);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int kind;
    logic [3:0] web;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      web  = (kind == 2) ? 4'($urandom_range(0, 14)) : 4'hF;
      drive_access("random", kind == 1, kind >= 2, web, $urandom & 32'hFFFF_FFFC, $urandom,
                   1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                   $urandom_range(0, 3), $urandom_range(0, 3));
    end
    checks++;
    if (proto_err != 0) begin
      errors++; $display("FAIL one_outstanding: got %0d overlapping requests want 0", proto_err);
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_im = '0; exp_dm = '0;
    t_done = 1'b0; t_rdata = '0; gnt_delay = 0; done_delay = 0;
    rst = 1'b1;
    set_idle();
    mem[32'h10]        = 32'h0000_0093;
    mem[32'h0001_0004] = 32'hDEAD_BEEF;
    mem[32'h14]        = 32'h0000_0013;
    test_reset();
    test_fetch_only();
    test_load_fetch();
    test_store_delayed_gnt();
    test_masked_write();
    test_reset_mid_txn();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 32, giving the data width of all data buses.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port im_read_mem, input, 1 bit: CPU instruction-fetch request.
REQ-005 The block SHALL have port im_addr, input, 32 bits: fetch byte address.
REQ-006 The block SHALL have port im_dataout, output, DATA_SIZE bits: returned instruction.
REQ-007 The block SHALL have ports dm_read_mem and dm_write_mem, input, 1 bit each: CPU data read request and data write request.
REQ-008 The block SHALL have port dm_addr, input, 32 bits: data byte address.
REQ-009 The block SHALL have port dm_datain, input, DATA_SIZE bits: write data.
REQ-010 The block SHALL have port dm_web, input, 4 bits: active-low byte write enables.
REQ-011 The block SHALL have port dm_dataout, output, DATA_SIZE bits: returned load data.
REQ-012 The block SHALL have port bus_stall, output, 1 bit: freezes all CPU pipeline registers while high.
REQ-013 The block SHALL have ports m_req, output, 1 bit, and m_write, output, 1 bit (1 = write): shared-bus request.
REQ-014 The block SHALL have ports m_addr, output, 32 bits; m_wdata, output, DATA_SIZE bits; and m_wstrb, output, 4 bits, active-high byte strobes.
REQ-015 The block SHALL have port m_gnt, input, 1 bit: the bus accepts the request at a clock edge where m_req and m_gnt are both high.
REQ-016 The block SHALL have ports m_done, input, 1 bit, and m_rdata, input, DATA_SIZE bits: access complete, with read data valid in the same cycle.

Function
REQ-017 The FSM SHALL have the states IDLE, DM_REQ, DM_WAIT, IM_REQ, IM_WAIT and DONE.
REQ-018 In IDLE, a data access SHALL be pending when dm_read_mem=1, or when dm_write_mem=1 and dm_web!=4'b1111; a write with dm_web=4'b1111 SHALL be treated as no access.
REQ-019 In IDLE, bus_stall SHALL be driven combinationally high in the same cycle that any access is pending (data access or im_read_mem).
REQ-020 In IDLE, when no access is pending, bus_stall SHALL be 0, the state SHALL remain IDLE, and no bus traffic SHALL occur.
REQ-021 On leaving IDLE, the block SHALL latch im_addr, dm_addr, dm_datain, ~dm_web and the access type into internal registers; outputs m_addr, m_wdata and m_wstrb SHALL come only from these latches.
REQ-022 Ordering: the data access (older instruction) SHALL be served before the fetch; from IDLE the next state SHALL be DM_REQ if a data access is pending, else IM_REQ.
REQ-023 In DM_REQ and IM_REQ, m_req SHALL be 1 and the address, data, strobe and m_write values SHALL be held stable until a cycle with m_gnt=1.
REQ-024 That m_gnt=1 cycle SHALL move the state to the matching WAIT state.
REQ-025 A fetch request SHALL drive m_write=0 and m_wstrb=4'b0000.
REQ-026 In DM_WAIT and IM_WAIT, m_req SHALL be 0, and m_done SHALL be sampled only in these states; m_done in any other state SHALL be ignored.
REQ-027 When m_done=1 in DM_WAIT on a read, m_rdata SHALL be registered into dm_dataout; a write SHALL leave dm_dataout unchanged.
REQ-028 On m_done=1 in DM_WAIT, the next state SHALL be IM_REQ if im_read_mem was latched, else DONE.
REQ-029 When m_done=1 in IM_WAIT, m_rdata SHALL be registered into im_dataout and the next state SHALL be DONE.
REQ-030 bus_stall SHALL be 1 in every state except IDLE-with-nothing-pending and DONE.
REQ-031 DONE SHALL last exactly one cycle with bus_stall=0, during which the CPU advances on the held data; DONE SHALL go unconditionally to IDLE, and the still-present CPU request lines SHALL NOT be re-issued.
REQ-032 im_dataout and dm_dataout SHALL hold their last captured values until overwritten.
REQ-033 At most one bus transaction SHALL be outstanding at any time.
REQ-034 Minimum latency with m_gnt and m_done both immediate SHALL be: fetch-only 3 stalled cycles, data-plus-fetch 5 stalled cycles, then 1 DONE cycle.

Reset
REQ-035 While rst=1, the state SHALL be IDLE.
REQ-036 While rst=1, m_req, m_write, m_addr, m_wdata, m_wstrb, im_dataout, dm_dataout and all latches SHALL be 0.
REQ-037 While rst=1, bus_stall SHALL be 0.
REQ-038 Reset asserted mid-transaction SHALL abort it immediately: m_req SHALL drop asynchronously and no data SHALL be captured.
REQ-039 After reset is released, the first cycle SHALL be evaluated as IDLE.

Verification
REQ-040 Scenario 1: fetch only, im_addr=0x0000_0010, m_gnt and m_done immediate, m_rdata=0x0000_0093 -> bus_stall=1 for 3 cycles; m_addr=0x10 with m_write=0; im_dataout=0x93 in the DONE cycle with bus_stall=0.
REQ-041 Scenario 2: load dm_addr=0x0001_0004 plus fetch 0x14, m_rdata 0xDEAD_BEEF then 0x0000_0013 -> DM request issued before IM; dm_dataout=0xDEADBEEF and im_dataout=0x13 at DONE; 5 stalled cycles.
REQ-042 Scenario 3: store with dm_web=4'b1100, dm_datain=0x0000_ABCD, m_gnt delayed 4 cycles -> m_req held high 5 cycles with m_wstrb=4'b0011, m_wdata=0xABCD and m_write=1 stable throughout.
REQ-043 Scenario 4: dm_write_mem=1 with dm_web=4'b1111 and im_read_mem=0 -> bus_stall=0 and m_req never asserted.
REQ-044 Scenario 5: rst pulsed during DM_WAIT, then a spurious m_done -> state IDLE, outputs 0, m_done ignored, next request served normally.
REQ-045 Scenario 6: requests held constant through DONE -> exactly one transaction per access; two DONE cycles never back-to-back without an intervening IDLE.
